// File: rtl/l0_skew_buf_if.sv
// Bus bundle for l0_skew_buf: write port, read request/mode, read data and status.
// o_level exists only when L0_LEVEL_EN is defined.
interface l0_skew_buf_if #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
);
    // Handshake: a write is taken on any edge where wr is high and o_ready was high
    // (writes while full are dropped); rd has no back-pressure, and an o_valid[i]
    // pulse marks each cycle in which out row i carries a freshly popped entry.
    logic                 wr;
    logic [row*bw-1:0]    in;
    logic                 rd;
    logic                 mode;
    logic [row*bw-1:0]    out;
    logic [row-1:0]       o_valid;
    logic                 o_full;
    logic                 o_ready;
    logic                 o_empty;
`ifdef L0_LEVEL_EN
    logic [$clog2(depth+1)-1:0] o_level;
`endif
    logic                 dbg_mode_q;
    logic [row-1:0]       dbg_rd_en;

`ifdef L0_LEVEL_EN
    modport master (output wr, in, rd, mode,
                    input  out, o_valid, o_full, o_ready, o_empty, o_level, dbg_mode_q, dbg_rd_en);
    modport slave  (input  wr, in, rd, mode,
                    output out, o_valid, o_full, o_ready, o_empty, o_level, dbg_mode_q, dbg_rd_en);
`else
    modport master (output wr, in, rd, mode,
                    input  out, o_valid, o_full, o_ready, o_empty, dbg_mode_q, dbg_rd_en);
    modport slave  (input  wr, in, rd, mode,
                    output out, o_valid, o_full, o_ready, o_empty, dbg_mode_q, dbg_rd_en);
`endif
endinterface

// File: rtl/l0_skew_buf.sv
// West-edge L0 staging buffer: row parallel-write FIFOs read in broadcast or diagonal skew.
// Define L0_LEVEL_EN to add the o_level occupancy output (count of the last row).
module l0_skew_buf #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input logic          clk,
    input logic          reset,
    l0_skew_buf_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [aw-1:0] one_a = 1;
    localparam logic [cw-1:0] one_c = 1;
    localparam logic [cw-1:0] depth_c = cw'(depth);

    logic [bw-1:0]     mem    [row][depth];
    logic [aw-1:0]     wr_ptr [row];
    logic [aw-1:0]     rd_ptr [row];
    logic [cw-1:0]     cnt    [row];
    logic [row-1:0]    full, empty, pop;
    logic [row-1:0]    rd_en;
    logic [row-1:0]    o_valid_q;
    logic [row*bw-1:0] out_q;
    logic              mode_q;
    logic              wr_ok;

    always_comb begin
        full  = '0;
        empty = '0;
        pop   = '0;
        for (int i = 0; i < row; i++) begin
            full[i]  = (cnt[i] == depth_c);
            empty[i] = (cnt[i] == '0);
            pop[i]   = rd_en[i] && !empty[i];
        end
        wr_ok = bus.wr && !(|full);
    end

    // Storage is not reset; clearing the pointers and counts discards its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < row; i++) begin
            if (wr_ok) mem[i][wr_ptr[i]] <= bus.in[i*bw +: bw];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < row; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            rd_en     <= '0;
            mode_q    <= 1'b0;
            out_q     <= '0;
            o_valid_q <= '0;
        end else begin
            for (int i = 0; i < row; i++) begin
                if (wr_ok) wr_ptr[i] <= wr_ptr[i] + one_a;
                if (pop[i]) begin
                    out_q[i*bw +: bw] <= mem[i][rd_ptr[i]];
                    rd_ptr[i]         <= rd_ptr[i] + one_a;
                end
                if (wr_ok && !pop[i]) cnt[i] <= cnt[i] + one_c;
                else if (!wr_ok && pop[i]) cnt[i] <= cnt[i] - one_c;
            end
            o_valid_q <= pop;
            if (mode_q) rd_en <= {rd_en[row-2:0], bus.rd};
            else        rd_en <= {row{bus.rd}};
            // Mode only switches when no read is in flight, so a wavefront is never split.
            if (rd_en == '0 && !bus.rd) mode_q <= bus.mode;
        end
    end

    assign bus.out        = out_q;
    assign bus.o_valid    = o_valid_q;
    assign bus.o_full     = |full;
    assign bus.o_ready    = ~(|full);
    assign bus.o_empty    = &empty;
    assign bus.dbg_mode_q = mode_q;
    assign bus.dbg_rd_en  = rd_en;
`ifdef L0_LEVEL_EN
    assign bus.o_level    = cnt[row-1];
`endif
endmodule
